pmc_deserializer: RTL and testbench
===================================

PMC_DESERIALIZER -- requirements
Module: pmc_deserializer

Interface
REQ-001 Parameter NCH, default 32, number of pixel-matrix data channels (1..64).
REQ-002 Parameter WIDTH, default 16, bits per word per channel (2..32).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 sh  input  1  shift-enable window from the PMC controller, synchronous to clk.
REQ-006 pclk  input  1  single-cycle bit strobe, synchronous to clk; one bit per channel per strobe.
REQ-007 pm_data_dout  input  NCH  serial data, one bit per channel, sampled when pclk=1.
REQ-008 msb_first  input  1  1: first bit of a word lands in bit WIDTH-1; 0: in bit 0.
REQ-009 clear  input  1  synchronous clear of rdata, word_cnt, status flags.
REQ-010 rdata  output  NCH x WIDTH  last complete word per channel.
REQ-011 rvalid  output  1  one-cycle pulse when rdata is updated.
REQ-012 word_cnt  output  8  number of complete words since last clear/reset, saturating.
REQ-013 abort_err  output  1  sticky flag: word aborted by sh deassertion.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 States IDLE, WAITING, ACTIVE; typedef held in shared package.
REQ-016 IDLE: sh=1 -> WAITING; pclk ignored in IDLE.
REQ-017 WAITING: pclk=1 -> capture bit 0 of word into shadow register, bit counter=1, go ACTIVE; else sh=0 -> IDLE.
REQ-018 ACTIVE: pclk=1 with bit counter < WIDTH-1 -> capture bit, counter+1.
REQ-019 ACTIVE: pclk=1 with counter = WIDTH-1 -> capture final bit, copy full shadow to rdata next edge, rvalid=1 that cycle, counter=0, go WAITING.
REQ-020 ACTIVE: sh=0 and pclk=0 -> abort: discard shadow, counter=0, abort_err=1, go IDLE; rdata unchanged.
REQ-021 ACTIVE: sh=0 and pclk=1 same cycle -> bit accepted (REQ-018/019 apply), then IDLE; abort_err set only if word remains incomplete.
REQ-022 Bit position of k-th captured bit (k=0..WIDTH-1): WIDTH-1-k if msb_first else k.
REQ-023 msb_first sampled at WAITING->ACTIVE transition and held for the word; mid-word changes ignored.
REQ-024 rdata updated only atomically on word completion; partial words never visible.
REQ-025 rvalid latency: one clk after the pclk carrying the final bit.
REQ-026 word_cnt increments on each rvalid, saturates at 255.
REQ-027 clear=1: rdata=0, word_cnt=0, abort_err=0, state IDLE, counter 0, shadow discarded; clear dominates any simultaneous pclk/sh event.
REQ-028 Bit counter width = $clog2(WIDTH); no wrap beyond WIDTH-1.

Reset
REQ-029 rst_n=0: state IDLE, counter 0, shadow 0, rdata all 0, rvalid 0, word_cnt 0, abort_err 0, busy 0.
REQ-030 Reset asserted mid-word discards the word with no rvalid and no abort_err.

Structure
REQ-031 Package pmc_pkg holds state_t and default NCH/WIDTH constants.
REQ-032 One sub-module pmc_lane_shifter (WIDTH-bit shadow capture per channel, bit-index input), instantiated NCH times by generate loop; FSM and counters in top.

Verification
REQ-033 NCH=32, WIDTH=16, msb_first=1: sh=1, 16 pclk strobes with channel 0 bits 1,0,1,0... -> rdata[0]=16'hAAAA, rvalid one pulse, word_cnt=1.
REQ-034 Same bit stream with msb_first=0 -> rdata[0]=16'h5555.
REQ-035 sh dropped after 7 pclk strobes -> abort_err=1, rdata unchanged, no rvalid, state IDLE.
REQ-036 Three back-to-back words within one sh window, 0x1234/0xBEEF/0x0F0F on channel 5 -> three rvalid pulses, final rdata[5]=16'h0F0F, word_cnt=3.
REQ-037 rst_n pulsed low after 10 bits, then full word -> first rvalid shows only the post-reset word, abort_err=0.
REQ-038 NCH=4, WIDTH=8: 260 words -> word_cnt saturates at 255; clear -> word_cnt=0, rdata=0.

Source files
------------

// File: rtl/pmc_pkg.sv
// Shared types and default sizing for the pixel-matrix deserializer.
package pmc_pkg;

   localparam int NCH_DEFAULT   = 32;
   localparam int WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAITING,
      ST_ACTIVE
   } state_t;

endpackage

// File: rtl/pmc_lane_shifter.sv
// One channel's shadow word: drops a serial bit at an arbitrary index.
// word_next is the shadow as it will be after this edge, so the top can commit
// a finished word in the same cycle the final bit arrives.
module pmc_lane_shifter
   import pmc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             cap,
   input  logic             start,
   input  logic [IDXW-1:0]  idx,
   input  logic             din,
   output logic [WIDTH-1:0] word_next
);

   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (clr) begin
         shadow_d = '0;
      end else if (cap) begin
         if (start) begin
            shadow_d = '0;
         end
         shadow_d[idx] = din;
      end
   end

   assign word_next = shadow_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

endmodule

// File: rtl/pmc_deserializer.sv
// Pixel-matrix deserializer: collects WIDTH serial bits per channel inside an
// sh window and publishes complete words atomically on rdata with an rvalid pulse.
module pmc_deserializer
   import pmc_pkg::*;
#(
   parameter int NCH   = NCH_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sh,
   input  logic                      pclk,
   input  logic [NCH-1:0]            pm_data_dout,
   input  logic                      msb_first,
   input  logic                      clear,
   output logic [NCH-1:0][WIDTH-1:0] rdata,
   output logic                      rvalid,
   output logic [7:0]                word_cnt,
   output logic                      abort_err,
   output logic                      busy
);

   localparam int              IDXW     = $clog2(WIDTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   state_t                    state_q, state_d;
   logic [IDXW-1:0]           bit_cnt_q, bit_cnt_d;
   logic                      msb_q, msb_d;
   logic [NCH-1:0][WIDTH-1:0] rdata_q, rdata_d;
   logic                      rvalid_q, rvalid_d;
   logic [7:0]                word_cnt_q, word_cnt_d;
   logic                      abort_q, abort_d;

   logic                      cap;
   logic                      start;
   logic                      shadow_clr;
   logic                      commit;
   logic                      msb_eff;
   logic [IDXW-1:0]           bit_idx;
   logic [NCH-1:0][WIDTH-1:0] lane_word;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      msb_d      = msb_q;
      word_cnt_d = word_cnt_q;
      abort_d    = abort_q;
      cap        = 1'b0;
      start      = 1'b0;
      shadow_clr = 1'b0;
      commit     = 1'b0;
      msb_eff    = msb_q;

      if (clear) begin
         state_d    = ST_IDLE;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         abort_d    = 1'b0;
         shadow_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sh) begin
                  state_d = ST_WAITING;
               end
            end
            ST_WAITING: begin
               // Bit order is latched with the first bit and held for the word.
               if (pclk) begin
                  cap       = 1'b1;
                  start     = 1'b1;
                  msb_eff   = msb_first;
                  msb_d     = msb_first;
                  bit_cnt_d = IDXW'(1);
                  state_d   = ST_ACTIVE;
               end else if (!sh) begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               if (pclk) begin
                  cap = 1'b1;
                  if (bit_cnt_q == LAST_IDX) begin
                     commit    = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = sh ? ST_WAITING : ST_IDLE;
                  end else if (!sh) begin
                     shadow_clr = 1'b1;
                     bit_cnt_d  = '0;
                     abort_d    = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else if (!sh) begin
                  shadow_clr = 1'b1;
                  bit_cnt_d  = '0;
                  abort_d    = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      rvalid_d = commit;
      if (commit && (word_cnt_q != 8'hFF)) begin
         word_cnt_d = word_cnt_q + 8'd1;
      end
   end

   assign bit_idx = msb_eff ? (LAST_IDX - bit_cnt_q) : bit_cnt_q;

   always_comb begin
      rdata_d = rdata_q;
      if (clear) begin
         rdata_d = '0;
      end else if (commit) begin
         rdata_d = lane_word;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      pmc_lane_shifter #(
         .WIDTH (WIDTH),
         .IDXW  (IDXW)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (shadow_clr),
         .cap       (cap),
         .start     (start),
         .idx       (bit_idx),
         .din       (pm_data_dout[i]),
         .word_next (lane_word[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         msb_q      <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         word_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         msb_q      <= msb_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         word_cnt_q <= word_cnt_d;
         abort_q    <= abort_d;
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign word_cnt  = word_cnt_q;
   assign abort_err = abort_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pmc_deserializer.sv
// Bench for pmc_deserializer: words are chosen as parallel values, serialized in
// the requested bit order, and the reassembled rdata must equal the original word.
module tb_pmc_deserializer;

   localparam int NCH   = 32;
   localparam int WIDTH = 16;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      sh;
   logic                      pclk;
   logic [NCH-1:0]            pm_data_dout;
   logic                      msb_first;
   logic                      clear;
   logic [NCH-1:0][WIDTH-1:0] rdata;
   logic                      rvalid;
   logic [7:0]                word_cnt;
   logic                      abort_err;
   logic                      busy;

   int checks   = 0;
   int errors   = 0;
   int rv_count = 0;

   logic [NCH-1:0][WIDTH-1:0] exp_rdata;
   int                        exp_cnt;
   int                        exp_rv;
   logic                      exp_abort;

   pmc_deserializer #(
      .NCH   (NCH),
      .WIDTH (WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sh           (sh),
      .pclk         (pclk),
      .pm_data_dout (pm_data_dout),
      .msb_first    (msb_first),
      .clear        (clear),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .word_cnt     (word_cnt),
      .abort_err    (abort_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Independent tally of rvalid pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (rvalid === 1'b1) rv_count++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
         $error("[TB] check %s", tag);
      end
   endtask

   task automatic checkRdata(input string tag, input logic [NCH-1:0][WIDTH-1:0] expv);
      checks++;
      assert (rdata === expv) else begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, rdata, expv);
         $error("[TB] check %s", tag);
      end
   endtask

   task automatic applyStimulus(input logic [NCH-1:0] bits, input logic p, input logic s);
      pm_data_dout = bits;
      pclk         = p;
      sh           = s;
      tick();
   endtask

   function automatic logic [NCH-1:0][WIDTH-1:0] randWord();
      logic [NCH-1:0][WIDTH-1:0] w;
      int                        r;
      for (int i = 0; i < NCH; i++) begin
         r    = $urandom;
         w[i] = r[WIDTH-1:0];
      end
      return w;
   endfunction

   function automatic logic [NCH-1:0] randBits();
      int r;
      r = $urandom;
      return r[NCH-1:0];
   endfunction

   // Reference behaviour of a completed word.
   task automatic modelCommit(input logic [NCH-1:0][WIDTH-1:0] w);
      exp_rdata = w;
      exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      exp_rv++;
   endtask

   task automatic modelClear();
      exp_rdata = '0;
      exp_cnt   = 0;
      exp_abort = 1'b0;
   endtask

   task automatic startWindow();
      applyStimulus('0, 1'b0, 1'b1);
      checkOutput("busy_window", 64'(busy), 64'd1);
   endtask

   task automatic endWindow();
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("rvalid_low", 64'(rvalid), 64'd0);
      checkOutput("busy_idle", 64'(busy), 64'd0);
   endtask

   // Serializes w in the requested order; wiggle toggles msb_first mid-word.
   task automatic sendWord(input logic [NCH-1:0][WIDTH-1:0] w, input logic msb,
                           input int max_gap, input bit wiggle, input bit drop_last);
      logic [NCH-1:0] bits;
      int             pos;
      for (int k = 0; k < WIDTH; k++) begin
         pos = msb ? (WIDTH - 1 - k) : k;
         for (int i = 0; i < NCH; i++) bits[i] = w[i][pos];
         if (k == 0) msb_first = msb;
         else if (wiggle) msb_first = 1'($urandom_range(0, 1));
         if (k == WIDTH - 1) begin
            applyStimulus(bits, 1'b1, !drop_last);
            modelCommit(w);
            checkOutput("rvalid_pulse", 64'(rvalid), 64'd1);
            checkRdata("rdata_word", exp_rdata);
         end else begin
            applyStimulus(bits, 1'b1, 1'b1);
            if (k == WIDTH / 2) checkRdata("rdata_partial_hidden", exp_rdata);
            repeat ($urandom_range(0, max_gap)) applyStimulus(randBits(), 1'b0, 1'b1);
         end
      end
   endtask

   task automatic sendPartial(input int n);
      msb_first = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) applyStimulus(randBits(), 1'b1, 1'b1);
   endtask

   initial begin
      logic [NCH-1:0][WIDTH-1:0] w;
      logic [15:0]               seq [3];
      seq[0] = 16'h1234;
      seq[1] = 16'hBEEF;
      seq[2] = 16'h0F0F;

      rst_n = 1'b0; sh = 1'b0; pclk = 1'b0; msb_first = 1'b1; clear = 1'b0;
      pm_data_dout = '0;
      exp_rdata = '0; exp_cnt = 0; exp_rv = 0; exp_abort = 1'b0;
      $display("[TB] start");
      tick(); tick();
      checkRdata("reset_rdata", '0);
      checkOutput("reset_rvalid", 64'(rvalid), 64'd0);
      checkOutput("reset_cnt", 64'(word_cnt), 64'd0);
      checkOutput("reset_abort", 64'(abort_err), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // pclk is ignored while idle
      applyStimulus('1, 1'b1, 1'b0);
      checkOutput("idle_ignores_pclk", 64'(busy), 64'd0);

      // 1,0,1,0... on channel 0, MSB first
      w = randWord(); w[0] = 16'hAAAA;
      startWindow();
      sendWord(w, 1'b1, 0, 1'b0, 1'b0);
      endWindow();
      checkOutput("msb_ch0", 64'(rdata[0]), 64'hAAAA);
      checkOutput("msb_cnt", 64'(word_cnt), 64'd1);
      checkOutput("msb_rv_count", 64'(rv_count), 64'(exp_rv));

      // Same stream, LSB first
      w = randWord(); w[0] = 16'h5555;
      startWindow();
      sendWord(w, 1'b0, 1, 1'b0, 1'b0);
      endWindow();
      checkOutput("lsb_ch0", 64'(rdata[0]), 64'h5555);

      // sh dropped after 7 strobes
      startWindow();
      sendPartial(7);
      applyStimulus('0, 1'b0, 1'b0);
      exp_abort = 1'b1;
      checkOutput("abort_flag", 64'(abort_err), 64'(exp_abort));
      checkOutput("abort_idle", 64'(busy), 64'd0);
      checkRdata("abort_rdata_kept", exp_rdata);
      checkOutput("abort_no_rvalid", 64'(rv_count), 64'(exp_rv));

      // Three back-to-back words in one window on channel 5
      startWindow();
      for (int n = 0; n < 3; n++) begin
         w = randWord(); w[5] = seq[n];
         sendWord(w, 1'b1, 2, 1'b1, 1'b0);
      end
      endWindow();
      checkOutput("b2b_ch5", 64'(rdata[5]), 64'h0F0F);
      checkOutput("b2b_cnt", 64'(word_cnt), 64'(exp_cnt));
      checkOutput("b2b_rv_count", 64'(rv_count), 64'(exp_rv));
      checkOutput("abort_sticky", 64'(abort_err), 64'd1);

      // Final bit arriving with sh low completes without abort
      clear = 1'b1; tick(); clear = 1'b0; modelClear();
      checkRdata("clear_rdata", exp_rdata);
      checkOutput("clear_abort", 64'(abort_err), 64'd0);
      startWindow();
      sendWord(randWord(), 1'b1, 0, 1'b0, 1'b1);
      checkOutput("droplast_busy", 64'(busy), 64'd0);
      checkOutput("droplast_abort", 64'(abort_err), 64'd0);

      // Non-final bit with sh low aborts
      startWindow();
      sendPartial(4);
      applyStimulus(randBits(), 1'b1, 1'b0);
      checkOutput("dropmid_abort", 64'(abort_err), 64'd1);
      checkRdata("dropmid_rdata", exp_rdata);

      // clear beats a simultaneous strobe
      startWindow();
      sendPartial(5);
      clear = 1'b1;
      applyStimulus('1, 1'b1, 1'b1);
      clear = 1'b0;
      modelClear();
      checkOutput("clear_dominates_busy", 64'(busy), 64'd0);
      checkOutput("clear_dominates_cnt", 64'(word_cnt), 64'd0);
      checkRdata("clear_dominates_rdata", exp_rdata);
      applyStimulus('0, 1'b0, 1'b0);

      // Randomized words, order and gaps
      for (int n = 0; n < 12; n++) begin
         startWindow();
         repeat ($urandom_range(1, 3)) begin
            sendWord(randWord(), 1'($urandom_range(0, 1)), 3, 1'b1, 1'b0);
         end
         endWindow();
      end
      checkOutput("rand_cnt", 64'(word_cnt), 64'(exp_cnt));
      checkOutput("rand_rv_count", 64'(rv_count), 64'(exp_rv));

      // Reset in the middle of a word
      startWindow();
      sendPartial(10);
      rst_n = 1'b0;
      applyStimulus('0, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 1'b0);
      rst_n = 1'b1;
      modelClear();
      checkRdata("midreset_rdata", exp_rdata);
      checkOutput("midreset_abort", 64'(abort_err), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_no_rvalid", 64'(rv_count), 64'(exp_rv));
      startWindow();
      sendWord(randWord(), 1'b1, 1, 1'b0, 1'b0);
      endWindow();
      checkOutput("postreset_cnt", 64'(word_cnt), 64'd1);
      checkOutput("postreset_abort", 64'(abort_err), 64'd0);

      // Saturation of word_cnt
      startWindow();
      for (int n = 0; n < 260; n++) sendWord(randWord(), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
      endWindow();
      checkOutput("sat_cnt", 64'(word_cnt), 64'd255);
      checkOutput("sat_model", 64'(exp_cnt), 64'd255);
      checkOutput("sat_rv_count", 64'(rv_count), 64'(exp_rv));
      clear = 1'b1; tick(); clear = 1'b0; modelClear();
      checkOutput("sat_clear_cnt", 64'(word_cnt), 64'd0);
      checkRdata("sat_clear_rdata", exp_rdata);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
